data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised successor to the single-cycle data memory. It serves up to four RAM segments, selected by address tag, plus one MMIO window. Loads and stores are byte, halfword or word sized, with big-endian lane steering and sign/zero extension. Requests use a valid/ready handshake, RAM responses are registered, and MMIO accesses run under a wait/timeout FSM. It sits between the MEM pipeline stage and the memory/serial devices.

Parameters:
NUM_SEG, 4, number of RAM segments in use (1..4)
SEG_TAGS, 64'h1001_1004_7fff_0000, packed 16-bit addr[31:16] tags; segment i uses bits [63-16i -: 16]
SEG_AW, 10, word-address bits per segment (depth = 2**SEG_AW words)
MMIO_TAG, 16'hffff, addr[31:16] tag of the MMIO window
TIMEOUT, 255, MMIO cycles to wait for ack before an error response (1..65535)
INIT_FILE, "", $readmemh image loaded into segment 0 only; empty means no init

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous active-low reset
req_valid_in  in  1  request present
req_ready_out  out  1  controller can accept
req_we_in  in  1  1 = store, 0 = load
req_addr_in  in  32  byte address
req_wdata_in  in  32  store data, right-justified
req_size_in  in  2  00 byte, 01 half, 11 word; 10 illegal
req_unsigned_in  in  1  zero-extend loads when 1
resp_valid_out  out  1  one-cycle response pulse
resp_rdata_out  out  32  extended load data; 0 for stores and errors
resp_err_out  out  1  misaligned, illegal size, unmapped, or MMIO timeout
mmio_req_out  out  1  MMIO access pending
mmio_we_out  out  1  MMIO write
mmio_addr_out  out  4  addr[3:0]
mmio_wdata_out  out  32  req_wdata_in unmodified
mmio_rdata_in  in  32  MMIO read data
mmio_ack_in  in  1  MMIO completion

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE, req_ready_out=1, and every other output and the timeout counter set to 0. RAM contents are retained.
- Accept: the request is taken when req_valid_in && req_ready_out at the clock edge.
- Decode at accept:
  - err if req_size_in==10, half with addr[0]==1, word with addr[1:0]!=0, or a tag matching no enabled segment and not MMIO_TAG.
  - If several segment tags match, the lowest index wins.
- Lanes are big-endian:
  - Byte offset k maps to bits [31-8k -: 8].
  - A half at offset 0 maps to [31:16]; at offset 2 to [15:0].
  - Stores replicate the low byte or half of req_wdata_in across the lanes and set the byte-enables only for the addressed lanes.
- RAM store: the masked write happens at the accept edge. resp_valid_out=1 on the next cycle with rdata=0, err=0.
- RAM load: the word is read at the accept edge into a register. On the next cycle resp_valid_out=1 with the extracted lane, sign-extended unless req_unsigned_in.
- Error: no RAM or MMIO side effect. resp_valid_out=1 on the next cycle with rdata=0, err=1.
- RAM and error requests are fully pipelined:
  - req_ready_out stays 1, so back-to-back accepts give back-to-back responses.
  - A load issued the cycle after a store to the same word sees the stored data (write-first ordering).
- MMIO FSM, states IDLE -> MMIO_WAIT -> IDLE:
  - On accept: enter MMIO_WAIT, drop req_ready_out to 0, register mmio_req/we/addr/wdata, and clear the counter.
  - In MMIO_WAIT: mmio_req_out stays 1 and its fields are stable. The counter increments each cycle without ack.
  - Ack: on the first cycle with mmio_ack_in==1, capture mmio_rdata_in (extended per size/unsigned as for RAM) and drop mmio_req_out. Next cycle: resp_valid_out=1, err=0, return to IDLE with ready=1.
  - Timeout: when the counter reaches TIMEOUT without ack, drop mmio_req_out. Next cycle: resp_valid_out=1, err=1, rdata=0, return to IDLE.
  - Ack arriving on the same cycle the counter hits TIMEOUT: the ack wins.
  - mmio_ack_in outside MMIO_WAIT is ignored.
- Reset mid-operation: a pending MMIO access is abandoned (mmio_req_out=0 next cycle) and no response is issued. A RAM write accepted on the same edge as reset==0 is not performed.
- resp_valid_out is never asserted for two cycles for one request. There is no response backpressure.

Test Plan:
- SW 0x11223344 @0x10010008, then LW @0x10010008 -> resp next cycle, rdata=0x11223344, err=0. Back-to-back issue gives responses on consecutive cycles.
- SB 0x000000A5 @0x10010009, then LW @0x10010008 -> 0x11A53344. LB @0x10010009 -> 0xFFFFFFA5; LBU -> 0x000000A5. LH @0x1001000A -> 0x00003344.
- LH @0x10010001, SW @0x7fff0002, size 10, LW @0x20000000 -> each err=1, rdata=0. A following LW @0x7fff0000 shows no write occurred.
- LW @0xffff0004 with ack 3 cycles after req and mmio_rdata_in=0x00000041 -> mmio_addr_out=4, ready=0 while waiting, resp rdata=0x00000041. LB of 0x00000080 -> 0xFFFFFF80.
- TIMEOUT=8, MMIO write with no ack -> mmio_req_out high for 8 cycles, then resp err=1. Ack on exactly the 8th cycle -> err=0.
- reset=0 during MMIO_WAIT -> next cycle mmio_req_out=0, ready=1, no resp_valid_out. Data at 0x10010008 is preserved across the reset.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: MEM-stage data memory controller.
// Serves up to four tag-selected RAM segments with registered reads and byte-enabled
// writes, plus one MMIO window driven by a wait/timeout FSM. Lanes are big-endian;
// MMIO read data is treated as right-justified (devices return data in the low bits).
module data_memory_ctrl #(
  parameter int          NUM_SEG   = 4,
  parameter logic [63:0] SEG_TAGS  = 64'h1001_1004_7fff_0000,
  parameter int          SEG_AW    = 10,
  parameter logic [15:0] MMIO_TAG  = 16'hffff,
  parameter int          TIMEOUT   = 255,
  parameter string       INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_we_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  output logic        resp_valid_out,
  output logic [31:0] resp_rdata_out,
  output logic        resp_err_out,
  output logic        mmio_req_out,
  output logic        mmio_we_out,
  output logic [3:0]  mmio_addr_out,
  output logic [31:0] mmio_wdata_out,
  input  logic [31:0] mmio_rdata_in,
  input  logic        mmio_ack_in
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // What the registered response should return as data.
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_RAM  = 2'd1;
  localparam logic [1:0] K_MMIO = 2'd2;

  localparam int          DEPTH     = 1 << SEG_AW;
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  // ---------------- state ----------------
  logic [0:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [1:0]  resp_kind_q, resp_kind_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        ld_uns_q, ld_uns_d;
  logic [1:0]  seg_sel_q, seg_sel_d;
  logic        mmio_req_q, mmio_req_d;
  logic        mmio_we_q, mmio_we_d;
  logic [3:0]  mmio_addr_q, mmio_addr_d;
  logic [31:0] mmio_wdata_q, mmio_wdata_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic [15:0] cnt_q, cnt_d;

  // ---------------- request decode ----------------
  logic [15:0]       tag;
  logic              seg_hit;
  logic [1:0]        seg_idx;
  logic              mmio_hit;
  logic              dec_err;
  logic              accept;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [31:0]       st_data;
  logic [3:0]        st_be;
  logic [SEG_AW-1:0] word_idx;
  logic              unused_addr;

  assign tag         = req_addr_in[31:16];
  assign word_idx    = req_addr_in[SEG_AW+1:2];
  assign mmio_hit    = (tag == MMIO_TAG);
  assign unused_addr = ^req_addr_in;

  // Segment match; scanning from the top down lets the lowest index win.
  always_comb begin
    seg_hit = 1'b0;
    seg_idx = 2'd0;
    for (int i = NUM_SEG - 1; i >= 0; i--) begin
      if (SEG_TAGS[63-16*i -: 16] == tag) begin
        seg_hit = 1'b1;
        seg_idx = i[1:0];
      end
    end
  end

  // Size/alignment/mapping errors and big-endian store lane steering.
  always_comb begin
    dec_err = (req_size_in == 2'b10) ||
              (req_size_in == 2'b01 && req_addr_in[0]) ||
              (req_size_in == 2'b11 && req_addr_in[1:0] != 2'b00) ||
              (!seg_hit && !mmio_hit);
    case (req_size_in)
      2'b00: begin
        st_data = {4{req_wdata_in[7:0]}};
        st_be   = 4'b1000 >> req_addr_in[1:0];
      end
      2'b01: begin
        st_data = {2{req_wdata_in[15:0]}};
        st_be   = req_addr_in[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        st_data = req_wdata_in;
        st_be   = 4'b1111;
      end
    endcase
  end

  // A write presented while reset is asserted must not reach the RAM.
  assign accept    = req_valid_in && ready_q;
  assign ram_wr_en = accept && reset && req_we_in && seg_hit && !dec_err;
  assign ram_rd_en = accept && reset && !req_we_in && seg_hit && !dec_err;

  // ---------------- RAM segments ----------------
  logic [31:0] seg_rd_word [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_seg
    if (gi < NUM_SEG) begin : g_ram
      logic [31:0] mem [DEPTH];
      logic [31:0] rd_q;
      logic        sel;

      assign sel = (seg_idx == 2'(gi));

      // Byte-enabled write and registered read of the addressed word.
      always_ff @(posedge clock) begin
        if (ram_wr_en && sel) begin
          for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
          end
        end
        if (ram_rd_en && sel) rd_q <= mem[word_idx];
      end

      assign seg_rd_word[gi] = rd_q;
    end else begin : g_none
      assign seg_rd_word[gi] = '0;
    end
  end

  // ---------------- control FSM ----------------
  // Next-state: RAM/error requests respond next cycle; MMIO parks in WAIT until ack or timeout.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_kind_d  = K_NONE;
    ld_size_d    = ld_size_q;
    ld_off_d     = ld_off_q;
    ld_uns_d     = ld_uns_q;
    seg_sel_d    = seg_sel_q;
    mmio_req_d   = mmio_req_q;
    mmio_we_d    = mmio_we_q;
    mmio_addr_d  = mmio_addr_q;
    mmio_wdata_d = mmio_wdata_q;
    mmio_rdata_d = mmio_rdata_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ld_size_d = req_size_in;
          ld_off_d  = req_addr_in[1:0];
          ld_uns_d  = req_unsigned_in;
          if (dec_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (seg_hit) begin
            resp_valid_d = 1'b1;
            resp_kind_d  = req_we_in ? K_NONE : K_RAM;
            seg_sel_d    = seg_idx;
          end else begin
            state_d      = ST_WAIT;
            ready_d      = 1'b0;
            mmio_req_d   = 1'b1;
            mmio_we_d    = req_we_in;
            mmio_addr_d  = req_addr_in[3:0];
            mmio_wdata_d = req_wdata_in;
            cnt_d        = '0;
          end
        end
      end
      default: begin
        if (mmio_ack_in) begin
          // Ack takes priority even on the cycle the counter would expire.
          mmio_req_d   = 1'b0;
          mmio_rdata_d = mmio_rdata_in;
          resp_valid_d = 1'b1;
          resp_kind_d  = mmio_we_q ? K_NONE : K_MMIO;
          state_d      = ST_IDLE;
          ready_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TIMEOUT_W) begin
            mmio_req_d   = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = ST_IDLE;
            ready_d      = 1'b1;
          end
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset; RAM contents are untouched.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_kind_q  <= K_NONE;
      ld_size_q    <= 2'b00;
      ld_off_q     <= 2'b00;
      ld_uns_q     <= 1'b0;
      seg_sel_q    <= 2'd0;
      mmio_req_q   <= 1'b0;
      mmio_we_q    <= 1'b0;
      mmio_addr_q  <= 4'd0;
      mmio_wdata_q <= 32'd0;
      mmio_rdata_q <= 32'd0;
      cnt_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_kind_q  <= resp_kind_d;
      ld_size_q    <= ld_size_d;
      ld_off_q     <= ld_off_d;
      ld_uns_q     <= ld_uns_d;
      seg_sel_q    <= seg_sel_d;
      mmio_req_q   <= mmio_req_d;
      mmio_we_q    <= mmio_we_d;
      mmio_addr_q  <= mmio_addr_d;
      mmio_wdata_q <= mmio_wdata_d;
      mmio_rdata_q <= mmio_rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // ---------------- load data extraction ----------------
  logic [31:0] src_word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_word;

  // Pick the lane (big-endian for RAM, low bits for MMIO) and sign/zero extend.
  always_comb begin
    src_word = (resp_kind_q == K_MMIO) ? mmio_rdata_q : seg_rd_word[seg_sel_q];
    if (resp_kind_q == K_MMIO) begin
      byte_v = src_word[7:0];
      half_v = src_word[15:0];
    end else begin
      case (ld_off_q)
        2'd0:    byte_v = src_word[31:24];
        2'd1:    byte_v = src_word[23:16];
        2'd2:    byte_v = src_word[15:8];
        default: byte_v = src_word[7:0];
      endcase
      half_v = ld_off_q[1] ? src_word[15:0] : src_word[31:16];
    end
    case (ld_size_q)
      2'b00:   ext_word = ld_uns_q ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   ext_word = ld_uns_q ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: ext_word = src_word;
    endcase
  end

  assign req_ready_out  = ready_q;
  assign resp_valid_out = resp_valid_q;
  assign resp_err_out   = resp_err_q;
  assign resp_rdata_out = (resp_valid_q && resp_kind_q != K_NONE) ? ext_word : 32'd0;
  assign mmio_req_out   = mmio_req_q;
  assign mmio_we_out    = mmio_we_q;
  assign mmio_addr_out  = mmio_addr_q;
  assign mmio_wdata_out = mmio_wdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: RAM lanes/extension, decode errors, MMIO ack,
// MMIO timeout, and reset in the middle of an MMIO access.
module tb_data_memory_ctrl;

  logic        clock;
  logic        reset;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [1:0]  req_size_in;
  logic        req_unsigned_in;
  logic        resp_valid_out;
  logic [31:0] resp_rdata_out;
  logic        resp_err_out;
  logic        mmio_req_out;
  logic        mmio_we_out;
  logic [3:0]  mmio_addr_out;
  logic [31:0] mmio_wdata_out;
  logic [31:0] mmio_rdata_in;
  logic        mmio_ack_in;

  int checks = 0;
  int errors = 0;

  data_memory_ctrl #(.TIMEOUT(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .req_we_in       (req_we_in),
    .req_addr_in     (req_addr_in),
    .req_wdata_in    (req_wdata_in),
    .req_size_in     (req_size_in),
    .req_unsigned_in (req_unsigned_in),
    .resp_valid_out  (resp_valid_out),
    .resp_rdata_out  (resp_rdata_out),
    .resp_err_out    (resp_err_out),
    .mmio_req_out    (mmio_req_out),
    .mmio_we_out     (mmio_we_out),
    .mmio_addr_out   (mmio_addr_out),
    .mmio_wdata_out  (mmio_wdata_out),
    .mmio_rdata_in   (mmio_rdata_in),
    .mmio_ack_in     (mmio_ack_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    req_valid_in    = 1'b1;
    req_we_in       = we;
    req_addr_in     = addr;
    req_wdata_in    = wdata;
    req_size_in     = size;
    req_unsigned_in = uns;
  endtask

  // One RAM/error request, accepted at the next edge; response checked just after it.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_rdata, input logic exp_err);
    drive(we, addr, wdata, size, uns);
    step();
    req_valid_in = 1'b0;
    chk({tag, " valid"}, 32'(resp_valid_out), 32'd1);
    chk({tag, " rdata"}, resp_rdata_out, exp_rdata);
    chk({tag, " err"},   32'(resp_err_out), 32'(exp_err));
    $display("txn %s addr=%08h we=%0d size=%0d rdata=%08h err=%0d",
             tag, addr, we, size, resp_rdata_out, resp_err_out);
  endtask

  int n;

  initial begin
    reset           = 1'b0;
    req_valid_in    = 1'b0;
    req_we_in       = 1'b0;
    req_addr_in     = 32'd0;
    req_wdata_in    = 32'd0;
    req_size_in     = 2'b00;
    req_unsigned_in = 1'b0;
    mmio_rdata_in   = 32'd0;
    mmio_ack_in     = 1'b0;

    // Reset values
    step();
    step();
    chk("rst ready",    32'(req_ready_out),  32'd1);
    chk("rst valid",    32'(resp_valid_out), 32'd0);
    chk("rst rdata",    resp_rdata_out,      32'd0);
    chk("rst err",      32'(resp_err_out),   32'd0);
    chk("rst mmio_req", 32'(mmio_req_out),   32'd0);
    reset = 1'b1;
    step();

    // Store then load back-to-back (write-first across consecutive accepts)
    xfer("sw_a",  1'b1, 32'h1001_0008, 32'h1122_3344, 2'b11, 1'b0, 32'h0000_0000, 1'b0);
    xfer("lw_a",  1'b0, 32'h1001_0008, 32'h0,         2'b11, 1'b0, 32'h1122_3344, 1'b0);
    step();
    chk("idle valid", 32'(resp_valid_out), 32'd0);

    // Byte store and lane extraction
    xfer("sb",    1'b1, 32'h1001_0009, 32'h0000_00A5, 2'b00, 1'b0, 32'h0000_0000, 1'b0);
    xfer("lw_b",  1'b0, 32'h1001_0008, 32'h0,         2'b11, 1'b0, 32'h11A5_3344, 1'b0);
    xfer("lb",    1'b0, 32'h1001_0009, 32'h0,         2'b00, 1'b0, 32'hFFFF_FFA5, 1'b0);
    xfer("lbu",   1'b0, 32'h1001_0009, 32'h0,         2'b00, 1'b1, 32'h0000_00A5, 1'b0);
    xfer("lh2",   1'b0, 32'h1001_000A, 32'h0,         2'b01, 1'b0, 32'h0000_3344, 1'b0);
    xfer("lh0",   1'b0, 32'h1001_0008, 32'h0,         2'b01, 1'b0, 32'h0000_11A5, 1'b0);

    // Half store with negative value, segment isolation
    xfer("sh",    1'b1, 32'h1004_000A, 32'h1234_8001, 2'b01, 1'b0, 32'h0000_0000, 1'b0);
    xfer("lh_s1", 1'b0, 32'h1004_000A, 32'h0,         2'b01, 1'b0, 32'hFFFF_8001, 1'b0);
    xfer("lhu_s1",1'b0, 32'h1004_000A, 32'h0,         2'b01, 1'b1, 32'h0000_8001, 1'b0);
    xfer("lw_iso",1'b0, 32'h1001_0008, 32'h0,         2'b11, 1'b0, 32'h11A5_3344, 1'b0);
    xfer("sw_s3", 1'b1, 32'h0000_0010, 32'hA1B2_C3D4, 2'b11, 1'b0, 32'h0000_0000, 1'b0);
    xfer("lb_s3", 1'b0, 32'h0000_0013, 32'h0,         2'b00, 1'b1, 32'h0000_00D4, 1'b0);

    // Decode errors leave memory untouched
    xfer("sw_c",  1'b1, 32'h7fff_0000, 32'hCAFE_F00D, 2'b11, 1'b0, 32'h0000_0000, 1'b0);
    xfer("lh_mis",1'b0, 32'h1001_0001, 32'h0,         2'b01, 1'b0, 32'h0000_0000, 1'b1);
    xfer("sw_mis",1'b1, 32'h7fff_0002, 32'h1234_5678, 2'b11, 1'b0, 32'h0000_0000, 1'b1);
    xfer("sz10",  1'b1, 32'h7fff_0000, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0000_0000, 1'b1);
    xfer("unmap", 1'b0, 32'h2000_0000, 32'h0,         2'b11, 1'b0, 32'h0000_0000, 1'b1);
    xfer("lw_c",  1'b0, 32'h7fff_0000, 32'h0,         2'b11, 1'b0, 32'hCAFE_F00D, 1'b0);

    // Ack outside MMIO_WAIT is ignored
    mmio_ack_in = 1'b1;
    step();
    mmio_ack_in = 1'b0;
    chk("stray ack valid", 32'(resp_valid_out), 32'd0);
    chk("stray ack req",   32'(mmio_req_out),   32'd0);

    // MMIO load, ack in the third cycle of the request
    drive(1'b0, 32'hffff_0004, 32'h0, 2'b11, 1'b0);
    step();
    req_valid_in = 1'b0;
    chk("mm ld req",   32'(mmio_req_out),   32'd1);
    chk("mm ld addr",  32'(mmio_addr_out),  32'd4);
    chk("mm ld we",    32'(mmio_we_out),    32'd0);
    chk("mm ld ready", 32'(req_ready_out),  32'd0);
    step();
    step();
    chk("mm ld wait req", 32'(mmio_req_out),   32'd1);
    chk("mm ld wait vld", 32'(resp_valid_out), 32'd0);
    mmio_ack_in   = 1'b1;
    mmio_rdata_in = 32'h0000_0041;
    step();
    mmio_ack_in   = 1'b0;
    mmio_rdata_in = 32'd0;
    chk("mm ld valid", 32'(resp_valid_out), 32'd1);
    chk("mm ld rdata", resp_rdata_out,      32'h0000_0041);
    chk("mm ld err",   32'(resp_err_out),   32'd0);
    chk("mm ld drop",  32'(mmio_req_out),   32'd0);
    chk("mm ld rdy",   32'(req_ready_out),  32'd1);
    $display("txn mmio_lw addr=ffff0004 rdata=%08h err=%0d", resp_rdata_out, resp_err_out);
    step();
    chk("mm ld once", 32'(resp_valid_out), 32'd0);

    // MMIO signed byte load
    drive(1'b0, 32'hffff_0004, 32'h0, 2'b00, 1'b0);
    step();
    req_valid_in  = 1'b0;
    mmio_ack_in   = 1'b1;
    mmio_rdata_in = 32'h0000_0080;
    step();
    mmio_ack_in   = 1'b0;
    chk("mm lb rdata", resp_rdata_out, 32'hFFFF_FF80);
    $display("txn mmio_lb addr=ffff0004 rdata=%08h err=%0d", resp_rdata_out, resp_err_out);

    // MMIO write with no ack times out after 8 cycles
    drive(1'b1, 32'hffff_0008, 32'h1234_5678, 2'b11, 1'b0);
    step();
    req_valid_in = 1'b0;
    chk("to we",    32'(mmio_we_out),    32'd1);
    chk("to addr",  32'(mmio_addr_out),  32'd8);
    chk("to wdata", mmio_wdata_out,      32'h1234_5678);
    n = 0;
    while (mmio_req_out && n < 20) begin
      chk("to valid early", 32'(resp_valid_out), 32'd0);
      n++;
      step();
    end
    chk("to req cycles", 32'(n),              32'd8);
    chk("to valid",      32'(resp_valid_out), 32'd1);
    chk("to err",        32'(resp_err_out),   32'd1);
    chk("to rdata",      resp_rdata_out,      32'd0);
    $display("txn mmio_sw_timeout cycles=%0d err=%0d", n, resp_err_out);

    // Ack on exactly the 8th cycle beats the timeout
    drive(1'b1, 32'hffff_0008, 32'h0000_00AA, 2'b11, 1'b0);
    step();
    req_valid_in = 1'b0;
    repeat (7) step();
    chk("ack8 req", 32'(mmio_req_out), 32'd1);
    mmio_ack_in   = 1'b1;
    mmio_rdata_in = 32'h5555_5555;
    step();
    mmio_ack_in   = 1'b0;
    mmio_rdata_in = 32'd0;
    chk("ack8 valid", 32'(resp_valid_out), 32'd1);
    chk("ack8 err",   32'(resp_err_out),   32'd0);
    chk("ack8 rdata", resp_rdata_out,      32'd0);
    $display("txn mmio_sw_ack8 err=%0d", resp_err_out);

    // Reset during MMIO_WAIT abandons the access
    drive(1'b0, 32'hffff_0000, 32'h0, 2'b11, 1'b0);
    step();
    req_valid_in = 1'b0;
    chk("rw req", 32'(mmio_req_out), 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rw req drop", 32'(mmio_req_out),   32'd0);
    chk("rw ready",    32'(req_ready_out),  32'd1);
    chk("rw valid",    32'(resp_valid_out), 32'd0);
    step();
    chk("rw valid2",   32'(resp_valid_out), 32'd0);

    // Store presented on a reset edge is dropped
    reset = 1'b0;
    drive(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 2'b11, 1'b0);
    step();
    reset        = 1'b1;
    req_valid_in = 1'b0;
    chk("rst sw valid", 32'(resp_valid_out), 32'd0);
    xfer("lw_keep", 1'b0, 32'h1001_0008, 32'h0, 2'b11, 1'b0, 32'h11A5_3344, 1'b0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
